// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg
// Shared types and defaults for the run controller.
//   run_state_t       : controller state encoding
//   CW_DEFAULT        : default cycle-counter width
//   CLR_CYC_DEFAULT   : default number of core-reset cycles before a run
//   CORE_RESET_ON/OFF : core_reset polarity, shared with top_level
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } run_state_t;

    localparam int CW_DEFAULT      = 16;
    localparam int CLR_CYC_DEFAULT = 2;

    localparam logic CORE_RESET_ON  = 1'b1;
    localparam logic CORE_RESET_OFF = ~CORE_RESET_ON;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Unsigned up-counter that sticks at all-ones instead of wrapping.
//   clk    : system clock
//   reset  : synchronous active-low reset, clears q
//   clr    : synchronous clear, wins over en
//   en     : count enable
//   q      : current count
//   at_max : q is all-ones (saturated)
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] q,
    output logic          at_max
);

    localparam logic [CW-1:0] ONE = CW'(1);

    assign at_max = &q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && !at_max) begin
            q <= q + ONE;
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl
// Sequences one program execution on the 8-bit core: holds the core in
// reset while clearing the shift/carry flag, releases it, watches for the
// halt PC or a cycle limit, freezes the core after a drain cycle and
// reports the run length through a level req/done handshake.
//
// State table
//   state | meaning
//   IDLE  | waiting for req; core held in reset
//   CLEAR | core in reset, sc_clr asserted, lasts CLR_CYC cycles
//   RUN   | core enabled, cycles counting, halt/limit watched
//   DRAIN | one frozen cycle so the last flag/memory writes settle
//   DONE  | results visible until req drops
//
// Ports
//   clk, reset        : system clock, synchronous active-low reset
//   req               : run request (level)
//   prog_ctr, end_pc  : current PC and halt address
//   max_cycles        : RUN-cycle limit, 0 = no limit
//   core_reset        : reset to PC, reg_file and flags
//   core_en           : clock enable for the core state
//   sc_clr            : clears the shift/carry register
//   busy, done        : run in progress / run finished
//   timeout           : finished run hit max_cycles
//   cycles            : RUN cycles of the last or current run
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int D       = 12,
    parameter int CW      = CW_DEFAULT,
    parameter int CLR_CYC = CLR_CYC_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [D-1:0]  prog_ctr,
    input  logic [D-1:0]  end_pc,
    input  logic [CW-1:0] max_cycles,
    output logic          core_reset,
    output logic          core_en,
    output logic          sc_clr,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycles
);

    localparam int              CLW      = $clog2(CLR_CYC + 1);
    localparam logic [CLW-1:0]  CLR_LAST = CLW'(CLR_CYC - 1);
    localparam logic [CW-1:0]   ONE      = CW'(1);

    run_state_t state;
    run_state_t state_next;

    logic           start;
    logic           halt;
    logic           limit_hit;
    logic           clr_done;
    logic           run_en;
    logic           clr_cnt_clr;
    logic           clr_cnt_en;
    logic [CW-1:0]  cyc_q;
    logic [CW-1:0]  cyc_inc;
    logic           cyc_at_max;
    logic [CLW-1:0] clr_q;
    logic           clr_at_max;

    assign start       = (state == IDLE) && req;
    assign run_en      = (state == RUN);
    assign clr_cnt_clr = (state != CLEAR);
    assign clr_cnt_en  = (state == CLEAR);
    assign halt        = (prog_ctr == end_pc);

    // Limit is checked against the count this RUN cycle will leave behind.
    // A saturated counter does not move, so a limit of all-ones fires on the
    // cycle the counter reaches saturation.
    assign cyc_inc   = cyc_at_max ? cyc_q : cyc_q + ONE;
    assign limit_hit = (max_cycles != '0) && (cyc_inc == max_cycles);

    // at_max is only a guard; CLR_LAST is always reached first.
    assign clr_done = (clr_q == CLR_LAST) || clr_at_max;

    sat_counter #(
        .CW (CW)
    ) u_cyc_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (start),
        .en     (run_en),
        .q      (cyc_q),
        .at_max (cyc_at_max)
    );

    sat_counter #(
        .CW (CLW)
    ) u_clr_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr_cnt_clr),
        .en     (clr_cnt_en),
        .q      (clr_q),
        .at_max (clr_at_max)
    );

    assign cycles = cyc_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Halt has priority: a run that ends on its limiting cycle still drains
    // and is reported as a normal finish.
    always_ff @(posedge clk) begin
        if (!reset) begin
            timeout <= 1'b0;
        end else if (start) begin
            timeout <= 1'b0;
        end else if (run_en && !halt && limit_hit) begin
            timeout <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_done) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (halt) begin
                    state_next = DRAIN;
                end else if (limit_hit) begin
                    state_next = DONE;
                end
            end
            DRAIN: begin
                state_next = DONE;
            end
            DONE: begin
                if (!req) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        core_reset = CORE_RESET_OFF;
        core_en    = 1'b0;
        sc_clr     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                core_reset = CORE_RESET_ON;
            end
            CLEAR: begin
                core_reset = CORE_RESET_ON;
                sc_clr     = 1'b1;
                busy       = 1'b1;
            end
            RUN: begin
                core_en = 1'b1;
                busy    = 1'b1;
            end
            DRAIN: begin
                busy = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                core_reset = CORE_RESET_ON;
            end
        endcase
    end

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl
// Directed bench for run_ctrl: reset, normal halt, timeout, simultaneous
// halt/limit, limit of one, halt on first RUN cycle, req handshake and a
// mid-run reset. Expected values are hand-derived from the run timeline.
module tb_run_ctrl;

    localparam int D       = 12;
    localparam int CW      = 16;
    localparam int CLR_CYC = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic [D-1:0]  prog_ctr;
    logic [D-1:0]  end_pc;
    logic [CW-1:0] max_cycles;
    logic          core_reset;
    logic          core_en;
    logic          sc_clr;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycles;

    int n_chk  = 0;
    int n_pass = 0;

    run_ctrl #(
        .D       (D),
        .CW      (CW),
        .CLR_CYC (CLR_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .prog_ctr   (prog_ctr),
        .end_pc     (end_pc),
        .max_cycles (max_cycles),
        .core_reset (core_reset),
        .core_en    (core_en),
        .sc_clr     (sc_clr),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .cycles     (cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete run from IDLE. PC on RUN cycle i is base+i-1; the run is
    // expected to last run_len RUN cycles, then drain (halt) or not (timeout).
    task automatic run_seq(input int base, input int limit, input int run_len, input bit exp_drain);
        max_cycles = CW'(limit);
        prog_ctr   = D'(base);
        req        = 1'b1;
        tick();
        for (int c = 0; c < CLR_CYC; c++) begin
            chk("clear_sc_clr", sc_clr, 1);
            chk("clear_core_reset", core_reset, 1);
            chk("clear_busy", busy, 1);
            chk("clear_core_en", core_en, 0);
            chk("clear_cycles", cycles, 0);
            chk("clear_timeout", timeout, 0);
            tick();
        end
        for (int i = 1; i <= run_len; i++) begin
            prog_ctr = D'(base + i - 1);
            chk("run_core_en", core_en, 1);
            chk("run_core_reset", core_reset, 0);
            chk("run_sc_clr", sc_clr, 0);
            chk("run_cycles", cycles, i - 1);
            tick();
        end
        if (exp_drain) begin
            chk("drain_core_en", core_en, 0);
            chk("drain_busy", busy, 1);
            chk("drain_done", done, 0);
            chk("drain_cycles", cycles, run_len);
            tick();
        end
        chk("done_done", done, 1);
        chk("done_busy", busy, 0);
        chk("done_core_en", core_en, 0);
        chk("done_core_reset", core_reset, 0);
        chk("done_cycles", cycles, run_len);
        chk("done_timeout", timeout, exp_drain ? 0 : 1);
    endtask

    task automatic back_to_idle();
        req = 1'b0;
        tick();
        chk("idle_done", done, 0);
        chk("idle_core_reset", core_reset, 1);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        reset      = 1'b0;
        req        = 1'b0;
        prog_ctr   = '0;
        end_pc     = D'(128);
        max_cycles = '0;
        repeat (3) tick();
        chk("rst_core_reset", core_reset, 1);
        chk("rst_core_en", core_en, 0);
        chk("rst_sc_clr", sc_clr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_cycles", cycles, 0);
        reset = 1'b1;
        tick();
        chk("idle_busy_after_rst", busy, 0);

        // normal run, halt on RUN cycle 50
        run_seq(79, 0, 50, 1'b1);

        // req held through DONE: no restart
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_done", done, 1);
            chk("hold_busy", busy, 0);
            chk("hold_cycles", cycles, 50);
        end
        back_to_idle();
        chk("idle_cycles_hold", cycles, 50);

        // timeout after 20 RUN cycles, no drain; restart also checks clear
        run_seq(0, 20, 20, 1'b0);
        back_to_idle();

        // halt and limit on the same RUN cycle 10: halt wins
        run_seq(119, 10, 10, 1'b1);
        back_to_idle();

        // smallest limit
        run_seq(0, 1, 1, 1'b0);
        back_to_idle();

        // halt on the very first RUN cycle
        run_seq(128, 0, 1, 1'b1);
        back_to_idle();

        // mid-run reset on RUN cycle 7
        max_cycles = '0;
        prog_ctr   = '0;
        req        = 1'b1;
        tick();
        repeat (CLR_CYC) tick();
        for (int i = 1; i <= 7; i++) begin
            prog_ctr = D'(i);
            chk("mid_core_en", core_en, 1);
            if (i < 7) tick();
        end
        reset = 1'b0;
        req   = 1'b0;
        tick();
        chk("mid_busy", busy, 0);
        chk("mid_core_en_off", core_en, 0);
        chk("mid_core_reset", core_reset, 1);
        chk("mid_done", done, 0);
        chk("mid_cycles", cycles, 0);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mid_no_done", done, 0);
            chk("mid_idle_busy", busy, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run controller that sequences one program execution on the 8-bit core. A single `req`/`done` handshake with the bench or host drives the controller, which then holds the core in reset, clears the shift/carry flag, releases the core, and detects the end-of-program PC. It freezes the core after a drain cycle and reports the cycle count and whether a timeout occurred. It sits between the top-level `req`/`done` pins and the PC, register file and flag registers. It replaces the free-running `done = prog_ctr == 128` comparison.

## Interface
Parameters:
- `D`, 12: program counter width.
- `CW`, 16: cycle counter width.
- `CLR_CYC`, 2: number of cycles the core is held in reset before each run, ≥1.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req`  in  1  run request, level-sensitive.
- `prog_ctr`  in  D  current PC from the fetch unit.
- `end_pc`  in  D  halt address; must be stable while `busy`.
- `max_cycles`  in  CW  RUN-cycle limit; 0 disables the timeout.
- `core_reset`  out  1  active-high reset to PC, reg_file and flag registers.
- `core_en`  out  1  clock enable for PC, reg_file writes, dat_mem writes and flag registers.
- `sc_clr`  out  1  clears the shift/carry register.
- `busy`  out  1  high in CLEAR, RUN and DRAIN.
- `done`  out  1  run finished.
- `timeout`  out  1  the finished run hit `max_cycles`; valid while `done`.
- `cycles`  out  CW  RUN cycles consumed by the last or current run.

## Operation
- Moore FSM with states IDLE, CLEAR, RUN, DRAIN, DONE. All outputs are registered or decoded from the registered state only.
- **IDLE:**
  - Outputs: `core_reset=1`, `core_en=0`, `done=0`.
  - `req=1` → CLEAR.
- **CLEAR:**
  - Outputs: `core_reset=1`, `sc_clr=1`, `busy=1`.
  - On entry, `cycles` and `timeout` clear to 0.
  - The state lasts exactly `CLR_CYC` cycles, then → RUN.
- **RUN:**
  - Outputs: `core_en=1`, `core_reset=0`, `busy=1`.
  - `cycles` increments every RUN cycle and saturates at all-ones.
  - If `prog_ctr==end_pc`, go → DRAIN. That cycle is counted.
  - Otherwise, if `max_cycles≠0` and the post-increment count equals `max_cycles`, go → DONE with `timeout=1`.
  - If the halt and timeout conditions occur in the same cycle, halt wins and `timeout=0`.
- **DRAIN:**
  - Outputs: `core_en=0`, `busy=1`, one cycle. This lets the final flag and memory writes settle.
  - → DONE.
- **DONE:**
  - Outputs: `done=1`, `core_en=0`, `core_reset=0`. The core state stays visible for inspection.
  - `cycles` and `timeout` hold.
  - `req=0` → IDLE.
- `req` is ignored in CLEAR, RUN and DRAIN. A run cannot be aborted except by `reset`.
- If `req` is held high through DONE, no new run starts. A new run requires `req` to go low and then high again.

## Timing
- Reset values (`reset=0` at an edge): state IDLE, `core_reset=1`, `core_en=0`, `sc_clr=0`, `busy=0`, `done=0`, `timeout=0`, `cycles=0`.
- Reset asserted mid-run: IDLE on the next edge. No DONE is produced.
- If `req` is sampled high in IDLE at edge k:
  - CLEAR occupies cycles k+1 … k+`CLR_CYC`.
  - RUN starts at cycle k+`CLR_CYC`+1.
- Halt sampled in RUN at edge h: DRAIN at h+1, `done=1` from h+2.
- Timeout: `done=1` on the edge after the limiting RUN cycle. There is no DRAIN.
- `done` falls one cycle after `req` is sampled low.
- Counter width rules:
  - `cycles` is unsigned and saturating.
  - `max_cycles` is compared against the post-increment value.
  - If `max_cycles` is at or above the saturation value, the timeout occurs when the counter reaches saturation, in the same cycle.

## Structure
- Shared package `run_ctrl_pkg` contains:
  - `typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} run_state_t`.
  - Default `CW` and `CLR_CYC` localparams.
  - The `core_reset` polarity constant, imported by `top_level`.
- One sub-module, `sat_counter` (parameter `CW`; ports `clr`, `en`, `q`, `at_max`), implements `cycles`. It is also reused for the CLEAR-length count.

## Test plan
- Reset with `reset=0` for 3 cycles, `req=0` → `core_reset=1`, `done=0`, `cycles=0`, state IDLE.
- Normal run: `end_pc=128`, `max_cycles=0`, PC stubbed to reach 128 on the 50th RUN cycle, `req=1` → 2 CLEAR cycles with `sc_clr=1`, then 1 DRAIN cycle, then `done=1`, `cycles=50`, `timeout=0`.
- Timeout: `end_pc=128` never reached, `max_cycles=20` → `done=1` after the 20th RUN cycle, `timeout=1`, `cycles=20`, no DRAIN cycle.
- Simultaneous: halt and `max_cycles` both hit on RUN cycle 10 → DRAIN, `timeout=0`, `cycles=10`.
- Handshake: hold `req=1` after `done` for 5 cycles → no restart. Drop `req` → IDLE next cycle. Raise `req` → new CLEAR, `cycles` cleared to 0.
- Mid-run reset: assert `reset=0` on RUN cycle 7 → IDLE on the next edge, `core_en=0`, `busy=0`, `done` never asserted.
